// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: boot/run/halt FSM, prioritised next-PC select and EPC capture.
// Priority in RUN is exception > eret > unstalled branch > halt > stall > increment.
module pc_sequencer #(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int          STEP         = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall_f,
  input  logic                  branch_taken_d,
  input  logic [ADDR_WIDTH-1:0] branch_target_d,
  input  logic                  exception_m,
  input  logic [ADDR_WIDTH-1:0] exception_pc_m,
  input  logic                  eret_m,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc_f,
  output logic [ADDR_WIDTH-1:0] pc_plus_step_f,
  output logic                  pc_valid_f,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic                  misaligned_f
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC   = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] EXC_PC   = ADDR_WIDTH'(EXC_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A   = ADDR_WIDTH'(STEP);
  // STEP is a power of two, so STEP-1 masks the low offset bits (zero mask when STEP = 1).
  localparam logic [ADDR_WIDTH-1:0] ALN_MASK = STEP_A - 1'b1;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic                  vld_q, vld_d;

  assign pc_f           = pc_q;
  assign pc_valid_f     = vld_q;
  assign epc            = epc_q;
  assign pc_plus_step_f = pc_q + STEP_A;
  assign misaligned_f   = vld_q && ((pc_q & ALN_MASK) != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= RST_PC;
      vld_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      epc_q   <= epc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    epc_d   = epc_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        vld_d   = 1'b1;
      end
      RUN: begin
        if (exception_m) begin
          pc_d  = EXC_PC;
          epc_d = exception_pc_m;
        end else if (eret_m) begin
          pc_d = epc_q;
        end else if (branch_taken_d && !stall_f) begin
          pc_d = branch_target_d;
        end else if (halt) begin
          state_d = HALTED;
          vld_d   = 1'b0;
        end else if (!stall_f) begin
          pc_d = pc_plus_step_f;
        end
      end
      HALTED: begin
        if (exception_m) begin
          state_d = RUN;
          vld_d   = 1'b1;
          pc_d    = EXC_PC;
          epc_d   = exception_pc_m;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule
